// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory line arbiter: FSM states, registered
// operation kind, and the grant-index width helper.
package pmem_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    ARB_READ  = 1'b0,
    ARB_WRITE = 1'b1
  } arb_op_t;

  // A single channel still needs a 1-bit grant index.
  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pmem_arbiter_rr_picker.sv
// Combinational winner select: fixed priority (lowest index) or round-robin
// starting one past the previous winner and wrapping.
module rr_picker
  import pmem_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int RR_EN = 1,
  localparam int GRANT_W = grant_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0]  req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic               win_vld,
  output logic [GRANT_W-1:0] win_idx
);

  int idx;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (RR_EN != 0) ? ((int'(last_grant) + 1 + k) % NUM_CH) : k;
      if (!win_vld && req[idx[GRANT_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = idx[GRANT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// N-channel line arbiter in front of the cacheline adaptor: one line
// transaction at a time, request captured on grant, response passed through.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32,
  parameter int RR_EN = 1,
  localparam int GRANT_W = grant_width(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              ch_read,
  input  logic [NUM_CH-1:0]              ch_write,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_address,
  input  logic [NUM_CH-1:0][LINE_W-1:0]  ch_wdata,
  output logic [LINE_W-1:0]              ch_rdata,
  output logic [NUM_CH-1:0]              ch_resp,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [ADDR_W-1:0]              mem_address,
  output logic [LINE_W-1:0]              mem_wdata,
  input  logic [LINE_W-1:0]              mem_rdata,
  input  logic                           mem_resp,
  output logic                           busy,
  output logic [GRANT_W-1:0]             grant
);

  arb_state_t         state, state_nxt;
  arb_op_t            op_q;
  logic [GRANT_W-1:0] grant_q;
  logic [GRANT_W-1:0] last_grant;
  logic [ADDR_W-1:0]  addr_q;
  logic [LINE_W-1:0]  wdata_q;
  logic [NUM_CH-1:0]  req;
  logic               win_vld;
  logic [GRANT_W-1:0] win_idx;

  assign req = ch_read | ch_write;

  rr_picker #(
    .NUM_CH (NUM_CH),
    .RR_EN  (RR_EN)
  ) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .win_vld    (win_vld),
    .win_idx    (win_idx)
  );

  // Stage p0: grant capture. The client's request is frozen here so later
  // changes on its address/data lines cannot disturb the adaptor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= ARB_READ;
      grant_q    <= '0;
      last_grant <= GRANT_W'(NUM_CH - 1);
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_vld) begin
        grant_q    <= win_idx;
        last_grant <= win_idx;
        // read+write together is illegal; resolve it as a write
        op_q       <= ch_write[win_idx] ? ARB_WRITE : ARB_READ;
        addr_q     <= ch_address[win_idx];
        wdata_q    <= ch_wdata[win_idx];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ch_resp   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) state_nxt = BUSY;
      end
      BUSY: begin
        mem_read  = (op_q == ARB_READ);
        mem_write = (op_q == ARB_WRITE);
        if (mem_resp) begin
          ch_resp[grant_q] = 1'b1;
          state_nxt        = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy        = (state == BUSY);
  assign grant       = grant_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign ch_rdata    = mem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: three instances (2-ch RR, 2-ch fixed,
// 4-ch RR) driven by directed vectors against a fixed-latency adaptor model.
module tb_pmem_arbiter;

  localparam int LW  = 256;
  localparam int AW  = 32;
  localparam int LAT = 4;

  typedef struct packed {
    logic [3:0]    resp;
    logic [AW-1:0] addr;
    logic          wr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  exp_t a_q[$];
  exp_t b_q[$];
  exp_t c_q[$];
  exp_t ea, eb, ec;

  // instance A: 2 channels, round-robin
  logic [1:0]         a_rd, a_wr, a_resp;
  logic [1:0][AW-1:0] a_addr;
  logic [1:0][LW-1:0] a_wd;
  logic [LW-1:0]      a_rdata, a_mwdata, a_mrdata;
  logic [AW-1:0]      a_maddr;
  logic               a_mrd, a_mwr, a_busy;
  logic               a_mresp = 1'b0;
  logic [0:0]         a_grant;
  int                 a_cnt = 0;

  // instance B: 2 channels, fixed priority
  logic [1:0]         b_rd, b_wr, b_resp;
  logic [1:0][AW-1:0] b_addr;
  logic [1:0][LW-1:0] b_wd;
  logic [LW-1:0]      b_rdata, b_mwdata, b_mrdata;
  logic [AW-1:0]      b_maddr;
  logic               b_mrd, b_mwr, b_busy;
  logic               b_mresp = 1'b0;
  logic [0:0]         b_grant;
  int                 b_cnt = 0;

  // instance C: 4 channels, round-robin
  logic [3:0]         c_rd, c_wr, c_resp;
  logic [3:0][AW-1:0] c_addr;
  logic [3:0][LW-1:0] c_wd;
  logic [LW-1:0]      c_rdata, c_mwdata, c_mrdata;
  logic [AW-1:0]      c_maddr;
  logic               c_mrd, c_mwr, c_busy;
  logic               c_mresp = 1'b0;
  logic               c_mr = 1'b0;
  logic               c_spur = 1'b0;
  logic [1:0]         c_grant;
  int                 c_cnt = 0;

  pmem_arbiter #(.NUM_CH(2), .LINE_W(LW), .ADDR_W(AW), .RR_EN(1)) u_a (
    .clk(clk), .rst(rst), .ch_read(a_rd), .ch_write(a_wr), .ch_address(a_addr),
    .ch_wdata(a_wd), .ch_rdata(a_rdata), .ch_resp(a_resp), .mem_read(a_mrd),
    .mem_write(a_mwr), .mem_address(a_maddr), .mem_wdata(a_mwdata),
    .mem_rdata(a_mrdata), .mem_resp(a_mresp), .busy(a_busy), .grant(a_grant)
  );

  pmem_arbiter #(.NUM_CH(2), .LINE_W(LW), .ADDR_W(AW), .RR_EN(0)) u_b (
    .clk(clk), .rst(rst), .ch_read(b_rd), .ch_write(b_wr), .ch_address(b_addr),
    .ch_wdata(b_wd), .ch_rdata(b_rdata), .ch_resp(b_resp), .mem_read(b_mrd),
    .mem_write(b_mwr), .mem_address(b_maddr), .mem_wdata(b_mwdata),
    .mem_rdata(b_mrdata), .mem_resp(b_mresp), .busy(b_busy), .grant(b_grant)
  );

  pmem_arbiter #(.NUM_CH(4), .LINE_W(LW), .ADDR_W(AW), .RR_EN(1)) u_c (
    .clk(clk), .rst(rst), .ch_read(c_rd), .ch_write(c_wr), .ch_address(c_addr),
    .ch_wdata(c_wd), .ch_rdata(c_rdata), .ch_resp(c_resp), .mem_read(c_mrd),
    .mem_write(c_mwr), .mem_address(c_maddr), .mem_wdata(c_mwdata),
    .mem_rdata(c_mrdata), .mem_resp(c_mresp), .busy(c_busy), .grant(c_grant)
  );

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return {32{a[7:0] ^ 8'hA5}};
  endfunction

  function automatic exp_t mk(input logic [3:0] r, input logic [AW-1:0] a, input logic w);
    exp_t e;
    e.resp = r;
    e.addr = a;
    e.wr   = w;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic wait_resp(input int inst, input logic [1:0] ch, input string nm);
    logic       hit;
    logic [3:0] r;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      r = (inst == 0) ? {2'b00, a_resp} : (inst == 1) ? {2'b00, b_resp} : c_resp;
      hit = r[ch];
    end
    chk(nm, LW'(hit), LW'(1));
  endtask

  // Adaptor models: fixed latency LAT cycles after the request appears.
  always @(posedge clk) begin
    #1;
    a_mrdata = line_of(a_maddr);
    if (!(a_mrd || a_mwr) || a_mresp) begin a_cnt = 0; a_mresp = 1'b0; end
    else begin a_cnt++; if (a_cnt == LAT) a_mresp = 1'b1; end
  end

  always @(posedge clk) begin
    #1;
    b_mrdata = line_of(b_maddr);
    if (!(b_mrd || b_mwr) || b_mresp) begin b_cnt = 0; b_mresp = 1'b0; end
    else begin b_cnt++; if (b_cnt == LAT) b_mresp = 1'b1; end
  end

  always @(posedge clk) begin
    #1;
    c_mrdata = line_of(c_maddr);
    if (!(c_mrd || c_mwr) || c_mr) begin c_cnt = 0; c_mr = 1'b0; end
    else begin c_cnt++; if (c_cnt == LAT) c_mr = 1'b1; end
    c_mresp = c_mr | c_spur;
  end

  // Monitors: every completion pulse must match the next expected transaction.
  always @(negedge clk) begin
    if (a_resp != '0) begin
      if (a_q.size() == 0) chk("a_unexpected_resp", LW'(a_resp), LW'(0));
      else begin
        ea = a_q.pop_front();
        chk("a_resp", LW'(a_resp), LW'(ea.resp[1:0]));
        chk("a_rdata", a_rdata, line_of(ea.addr));
        chk("a_addr", LW'(a_maddr), LW'(ea.addr));
        chk("a_op_wr", LW'(a_mwr), LW'(ea.wr));
      end
    end
  end

  always @(negedge clk) begin
    if (b_resp != '0) begin
      if (b_q.size() == 0) chk("b_unexpected_resp", LW'(b_resp), LW'(0));
      else begin
        eb = b_q.pop_front();
        chk("b_resp", LW'(b_resp), LW'(eb.resp[1:0]));
        chk("b_rdata", b_rdata, line_of(eb.addr));
        chk("b_addr", LW'(b_maddr), LW'(eb.addr));
      end
    end
  end

  always @(negedge clk) begin
    if (c_resp != '0) begin
      if (c_q.size() == 0) chk("c_unexpected_resp", LW'(c_resp), LW'(0));
      else begin
        ec = c_q.pop_front();
        chk("c_resp", LW'(c_resp), LW'(ec.resp));
        chk("c_rdata", c_rdata, line_of(ec.addr));
        chk("c_addr", LW'(c_maddr), LW'(ec.addr));
        chk("c_op_wr", LW'(c_mwr), LW'(ec.wr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    a_rd = '0; a_wr = '0; a_addr = '0; a_wd = '0;
    b_rd = '0; b_wr = '0; b_addr = '0; b_wd = '0;
    c_rd = '0; c_wr = '0; c_addr = '0; c_wd = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", LW'(a_busy), LW'(0));
    chk("rst_mem_read", LW'(a_mrd), LW'(0));
    chk("rst_mem_write", LW'(a_mwr), LW'(0));
    chk("rst_mem_address", LW'(a_maddr), LW'(0));
    chk("rst_ch_resp", LW'(a_resp), LW'(0));
    chk("rst_grant", LW'(a_grant), LW'(0));
    chk("rst_c_grant", LW'(c_grant), LW'(0));
    chk("rst_c_wdata", c_mwdata, LW'(0));
    rst = 1'b0;

    // single read on ch0
    @(negedge clk);
    a_addr[0] = 32'h0000_1000;
    a_rd = 2'b01;
    a_q.push_back(mk(4'b0001, 32'h0000_1000, 1'b0));
    @(negedge clk);
    chk("single_mem_read", LW'(a_mrd), LW'(1));
    chk("single_mem_address", LW'(a_maddr), LW'(32'h0000_1000));
    chk("single_busy", LW'(a_busy), LW'(1));
    wait_resp(0, 2'd0, "single_resp_seen");
    chk("single_rdata", a_rdata, {32{8'hA5}});
    a_rd = 2'b00;
    @(negedge clk);
    chk("single_idle_after", LW'(a_busy), LW'(0));

    // round-robin with both channels reading continuously from reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_addr[0] = 32'h0000_0104;
    a_addr[1] = 32'h0000_0208;
    for (int k = 0; k < 4; k++)
      a_q.push_back((k % 2 == 0) ? mk(4'b0001, 32'h104, 1'b0) : mk(4'b0010, 32'h208, 1'b0));
    a_rd = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_resp(0, 2'(k % 2), "rr_resp_seen");
      chk("rr_grant", LW'(a_grant), LW'(k % 2));
      if (k == 3) a_rd = 2'b00;
      @(negedge clk);
      chk("rr_idle_gap", LW'(a_busy), LW'(0));
    end

    // fixed priority: ch0 starves ch1 until it drops
    b_addr[0] = 32'h0000_0010;
    b_addr[1] = 32'h0000_0020;
    for (int k = 0; k < 3; k++) b_q.push_back(mk(4'b0001, 32'h10, 1'b0));
    b_q.push_back(mk(4'b0010, 32'h20, 1'b0));
    b_rd = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_resp(1, 2'd0, "fp_ch0_resp_seen");
      if (k == 2) b_rd = 2'b10;
      @(negedge clk);
      chk("fp_idle_gap", LW'(b_busy), LW'(0));
    end
    wait_resp(1, 2'd1, "fp_ch1_resp_seen");
    chk("fp_ch1_grant", LW'(b_grant), LW'(1));
    b_rd = 2'b00;
    @(negedge clk);

    // write on ch1; client address/data change mid-transaction
    a_addr[1] = 32'h8000_0040;
    a_wd[1] = {8{32'h1234_5678}};
    a_wr = 2'b10;
    a_q.push_back(mk(4'b0010, 32'h8000_0040, 1'b1));
    @(negedge clk);
    chk("wr_mem_write", LW'(a_mwr), LW'(1));
    chk("wr_mem_read", LW'(a_mrd), LW'(0));
    chk("wr_grant", LW'(a_grant), LW'(1));
    a_addr[1] = 32'hDEAD_0000;
    a_wd[1] = '0;
    @(negedge clk);
    chk("wr_hold_address", LW'(a_maddr), LW'(32'h8000_0040));
    chk("wr_hold_wdata", a_mwdata, {8{32'h1234_5678}});
    chk("wr_hold_write", LW'(a_mwr), LW'(1));
    wait_resp(0, 2'd1, "wr_resp_seen");
    chk("wr_write_at_resp", LW'(a_mwr), LW'(1));
    a_wr = 2'b00;
    @(negedge clk);

    // reset two cycles into a read on ch1
    a_addr[1] = 32'h0000_0300;
    a_rd = 2'b10;
    @(negedge clk);
    chk("rst_mid_busy", LW'(a_busy), LW'(1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_read", LW'(a_mrd), LW'(0));
    chk("rst_mid_busy_drop", LW'(a_busy), LW'(0));
    chk("rst_mid_no_resp", LW'(a_resp), LW'(0));
    a_addr[0] = 32'h0000_00C0;
    a_rd = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    a_q.push_back(mk(4'b0001, 32'h0000_00C0, 1'b0));
    @(negedge clk);
    chk("post_rst_grant", LW'(a_grant), LW'(0));
    chk("post_rst_address", LW'(a_maddr), LW'(32'h0000_00C0));
    wait_resp(0, 2'd0, "post_rst_ch0_resp_seen");
    a_rd = 2'b10;
    a_q.push_back(mk(4'b0010, 32'h0000_0300, 1'b0));
    wait_resp(0, 2'd1, "post_rst_ch1_resp_seen");
    a_rd = 2'b00;
    @(negedge clk);

    // 4 channels: read+write on ch0 is a write
    c_addr[0] = 32'h0000_0440;
    c_rd = 4'b0001;
    c_wr = 4'b0001;
    c_q.push_back(mk(4'b0001, 32'h0000_0440, 1'b1));
    @(negedge clk);
    chk("illegal_mem_write", LW'(c_mwr), LW'(1));
    chk("illegal_mem_read", LW'(c_mrd), LW'(0));
    chk("illegal_grant", LW'(c_grant), LW'(0));
    wait_resp(2, 2'd0, "illegal_resp_seen");
    c_rd = 4'b0000;
    c_wr = 4'b0000;
    @(negedge clk);

    // 4 channels round-robin: after ch0, ch1 then ch3
    c_addr[1] = 32'h0000_0444;
    c_addr[3] = 32'h0000_044C;
    c_q.push_back(mk(4'b0010, 32'h0000_0444, 1'b0));
    c_q.push_back(mk(4'b1000, 32'h0000_044C, 1'b0));
    c_rd = 4'b1010;
    @(negedge clk);
    chk("c_rr_grant1", LW'(c_grant), LW'(1));
    wait_resp(2, 2'd1, "c_rr_ch1_resp_seen");
    c_rd = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    chk("c_rr_grant3", LW'(c_grant), LW'(3));
    wait_resp(2, 2'd3, "c_rr_ch3_resp_seen");
    c_rd = 4'b0000;
    @(negedge clk);

    // spurious adaptor response while idle
    c_spur = 1'b1;
    @(negedge clk);
    chk("spur_mem_resp_driven", LW'(c_mresp), LW'(1));
    chk("spur_ch_resp", LW'(c_resp), LW'(0));
    chk("spur_busy", LW'(c_busy), LW'(0));
    @(negedge clk);
    chk("spur_ch_resp2", LW'(c_resp), LW'(0));
    c_spur = 1'b0;
    repeat (2) @(negedge clk);

    chk("a_queue_drained", LW'(a_q.size()), LW'(0));
    chk("b_queue_drained", LW'(b_q.size()), LW'(0));
    chk("c_queue_drained", LW'(c_q.size()), LW'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
